ps2_scan_decoder: RTL and testbench
===================================

// Module: ps2_scan_decoder
// PURPOSE
//  Sits between ps2_kbd and the cpu keyboard port. Pops raw PS/2 set-2 scancodes from ps2_kbd,
//  tracks break/extended prefixes and shift state, and translates make codes to ASCII.
//  Results are buffered in a small FIFO that the cpu drains one byte per read strobe.
// PARAMETERS
//  FIFO_DEPTH   8  ASCII FIFO entries; power of 2, >= 2
//  POP_CYCLES   2  cycles kb_rdn is held low; covers ps2_kbd running on clk200m/2
//  SETTLE_CYCLES 2 cycles waited after the pop before kb_ready is sampled again
// PORTS
//  clk200m      in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  kb_data      in   8  scancode at head of ps2_kbd queue
//  kb_ready     in   1  ps2_kbd has a scancode
//  kb_rdn       out  1  active-low pop to ps2_kbd
//  cpu_rd       in   1  pop one ASCII byte (single-cycle pulse)
//  ascii_data   out  8  FIFO head (fall-through); 8'h00 when empty
//  ascii_valid  out  1  FIFO not empty
//  fifo_ovf     out  1  sticky: a character was dropped because the FIFO was full
//  shift_held   out  1  left or right shift currently down
// BEHAVIOUR
//  Reset: kb_rdn=1, ascii_valid=0, ascii_data=0, fifo_ovf=0, shift_held=0, FIFO empty,
//   all prefix flags clear, FSM=IDLE. Reset mid-operation aborts the pop at once.
//  FSM: IDLE -(kb_ready)-> POP -(POP_CYCLES elapsed)-> SETTLE -(SETTLE_CYCLES)-> DECODE -> IDLE.
//   POP: kb_rdn=0, kb_data latched in the first POP cycle. All other states: kb_rdn=1.
//   DECODE lasts exactly one cycle; end-to-end, scancode-in to ascii_valid = 1+POP+SETTLE+1 cycles.
//  Decode of latched code c:
//   c==F0: set brk; c==E0: set ext; no output.
//   else if ext: discard c; clear brk and ext.
//   else if c in {12,59}: shift_l/shift_r <= !brk; clear brk.
//   else if brk: key release; no output; clear brk.
//   else: push lut(c,shift_held) if nonzero; unmapped (lut=00) is discarded silently.
//  LUT: letters 1C..1A -> a-z / A-Z with shift; digits 16..45 -> 0-9 / shifted symbols;
//   29->20 space, 5A->0D enter, 66->08 backspace, 0D->09 tab, 76->1B esc; all others 00.
//  FIFO: cpu_rd with FIFO empty is ignored. Push when full: the character is dropped and
//   fifo_ovf is set. Simultaneous push and pop when full: both happen, no drop, no ovf.
//   fifo_ovf clears on the first cpu_rd that pops an entry. Pointers wrap modulo FIFO_DEPTH
//   (log2+1 bits, MSB distinguishes full from empty).
//  ascii_data/ascii_valid update the cycle after a push or pop (registered).
// CONFIGURATION
//  PS2_TYPEMATIC_FILTER_EN defined: the last accepted make code is remembered; a repeat of
//   that same make code with no intervening break is discarded (no push). Any break or a
//   different make code re-arms the filter. Shift codes are not filtered.
//  Undefined: each typematic repeat pushes a character.
// STRUCTURE
//  Shared package kbd_pkg: state enum (IDLE,POP,SETTLE,DECODE), scancode constants
//   (SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59), ASCII_NONE=00.
//  One sub-module: ps2_ascii_lut (combinational: code[7:0], shift -> ascii[7:0]).
//  FIFO is inline: register array plus pointers.
// TESTING
//  1C, kb_ready held -> exactly one kb_rdn low pulse of 2 cycles; ascii_data=61, valid 6 cycles after ready.
//  12,1C,F0,1C,F0,12 -> one byte 41; shift_held 1 then 0; cpu_rd -> valid=0, data=00.
//  E0,75 then E0,F0,75 -> no push; brk/ext clear; next 1C -> 61.
//  9 x 1C (filter off), no cpu_rd -> 8 bytes 61, fifo_ovf=1; cpu_rd -> ovf=0; cpu_rd on empty -> no change.
//  Full FIFO with cpu_rd in the same cycle as a push -> count stays 8, fifo_ovf stays 0.
//  rst asserted mid-POP -> kb_rdn=1 immediately, FIFO empty; 1C,1C,1C -> one byte with
//   PS2_TYPEMATIC_FILTER_EN, three bytes without.

Source files
------------

// File: rtl/kbd_pkg.sv
// ============================================================================
// kbd_pkg : shared FSM state type and PS/2 set-2 scancode constants. Rev 1.0
// ============================================================================
`default_nettype none

package kbd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POP    = 2'd1,
      SETTLE = 2'd2,
      DECODE = 2'd3
   } kbd_state_t;

   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [7:0] ASCII_NONE = 8'h00;

   function automatic logic is_shift_code(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
// ============================================================================
// ps2_ascii_lut : combinational set-2 make code + shift -> ASCII. Rev 1.0
// ============================================================================
`default_nettype none

module ps2_ascii_lut
   import kbd_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic       i_shift,
   output logic [7:0] o_ascii
);

   logic [7:0] w_base;
   logic [7:0] w_alt;
   logic       w_letter;

   always_comb begin
      w_base   = ASCII_NONE;
      w_alt    = ASCII_NONE;
      w_letter = 1'b0;
      case (i_code)
         // letters: only the lower-case value is listed, upper case is derived
         8'h1C: w_base = 8'h61;
         8'h32: w_base = 8'h62;
         8'h21: w_base = 8'h63;
         8'h23: w_base = 8'h64;
         8'h24: w_base = 8'h65;
         8'h2B: w_base = 8'h66;
         8'h34: w_base = 8'h67;
         8'h33: w_base = 8'h68;
         8'h43: w_base = 8'h69;
         8'h3B: w_base = 8'h6A;
         8'h42: w_base = 8'h6B;
         8'h4B: w_base = 8'h6C;
         8'h3A: w_base = 8'h6D;
         8'h31: w_base = 8'h6E;
         8'h44: w_base = 8'h6F;
         8'h4D: w_base = 8'h70;
         8'h15: w_base = 8'h71;
         8'h2D: w_base = 8'h72;
         8'h1B: w_base = 8'h73;
         8'h2C: w_base = 8'h74;
         8'h3C: w_base = 8'h75;
         8'h2A: w_base = 8'h76;
         8'h1D: w_base = 8'h77;
         8'h22: w_base = 8'h78;
         8'h35: w_base = 8'h79;
         8'h1A: w_base = 8'h7A;
         8'h45: begin w_base = 8'h30; w_alt = 8'h29; end
         8'h16: begin w_base = 8'h31; w_alt = 8'h21; end
         8'h1E: begin w_base = 8'h32; w_alt = 8'h40; end
         8'h26: begin w_base = 8'h33; w_alt = 8'h23; end
         8'h25: begin w_base = 8'h34; w_alt = 8'h24; end
         8'h2E: begin w_base = 8'h35; w_alt = 8'h25; end
         8'h36: begin w_base = 8'h36; w_alt = 8'h5E; end
         8'h3D: begin w_base = 8'h37; w_alt = 8'h26; end
         8'h3E: begin w_base = 8'h38; w_alt = 8'h2A; end
         8'h46: begin w_base = 8'h39; w_alt = 8'h28; end
         8'h29: begin w_base = 8'h20; w_alt = 8'h20; end
         8'h5A: begin w_base = 8'h0D; w_alt = 8'h0D; end
         8'h66: begin w_base = 8'h08; w_alt = 8'h08; end
         8'h0D: begin w_base = 8'h09; w_alt = 8'h09; end
         8'h76: begin w_base = 8'h1B; w_alt = 8'h1B; end
         default: begin
            w_base = ASCII_NONE;
            w_alt  = ASCII_NONE;
         end
      endcase
      w_letter = (w_base >= 8'h61) && (w_base <= 8'h7A);
      if (w_letter) begin
         w_alt = w_base - 8'h20;
      end
   end

   assign o_ascii = i_shift ? w_alt : w_base;

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
// ============================================================================
// ps2_scan_decoder : pops PS/2 scancodes, tracks prefixes/shift, buffers ASCII.
// Option macro PS2_TYPEMATIC_FILTER_EN drops repeated make codes.   Rev 1.0
// ============================================================================
`default_nettype none

module ps2_scan_decoder
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int POP_CYCLES    = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk200m,
   input  logic       rst,
   input  logic [7:0] i_kb_data,
   input  logic       i_kb_ready,
   output logic       o_kb_rdn,
   input  logic       i_cpu_rd,
   output logic [7:0] o_ascii_data,
   output logic       o_ascii_valid,
   output logic       o_fifo_ovf,
   output logic       o_shift_held
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PW    = AW + 1;
   localparam int CMAX  = (POP_CYCLES > SETTLE_CYCLES) ? POP_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W = $clog2(CMAX) + 1;

   kbd_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_kb_rdn;
   logic [7:0]       r_code;
   logic             r_brk;
   logic             r_ext;
   logic             r_shift_l;
   logic             r_shift_r;

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [7:0]       r_ascii_data;
   logic             r_ascii_valid;
   logic             r_fifo_ovf;

   logic [7:0]       w_lut;
   logic             w_make;
   logic             w_repeat;
   logic             w_push;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr_en;
   logic             w_drop;
   logic [PW-1:0]    w_wr_nxt;
   logic [PW-1:0]    w_rd_nxt;
   logic [7:0]       w_head_nxt;
   logic             w_empty_nxt;

   ps2_ascii_lut u_lut (
      .i_code  (r_code),
      .i_shift (r_shift_l | r_shift_r),
      .o_ascii (w_lut)
   );

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [7:0] r_last_code;
   logic       r_last_vld;
   assign w_repeat = r_last_vld && (r_last_code == r_code);
`else
   assign w_repeat = 1'b0;
`endif

   // A plain make code: not a prefix, not part of an extended or break sequence, not shift.
   assign w_make = (r_state == DECODE) && (r_code != SC_BREAK) && (r_code != SC_EXT)
                   && !r_ext && !is_shift_code(r_code) && !r_brk;
   assign w_push = w_make && !w_repeat && (w_lut != ASCII_NONE);

   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_kb_rdn  <= 1'b1;
         r_code    <= 8'h00;
         r_brk     <= 1'b0;
         r_ext     <= 1'b0;
         r_shift_l <= 1'b0;
         r_shift_r <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         r_last_code <= 8'h00;
         r_last_vld  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_kb_rdn <= 1'b1;
               if (i_kb_ready) begin
                  r_state  <= POP;
                  r_kb_rdn <= 1'b0;
                  r_code   <= i_kb_data;
                  r_cnt    <= '0;
               end
            end
            POP: begin
               if (r_cnt == CNT_W'(POP_CYCLES - 1)) begin
                  r_state  <= SETTLE;
                  r_kb_rdn <= 1'b1;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SETTLE: begin
               r_kb_rdn <= 1'b1;
               if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  r_state <= DECODE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DECODE: begin
               r_state  <= IDLE;
               r_kb_rdn <= 1'b1;
               if (r_code == SC_BREAK) begin
                  r_brk <= 1'b1;
               end else if (r_code == SC_EXT) begin
                  r_ext <= 1'b1;
               end else if (r_ext) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                  if (r_brk) r_last_vld <= 1'b0;
`endif
                  r_brk <= 1'b0;
                  r_ext <= 1'b0;
               end else if (is_shift_code(r_code)) begin
                  if (r_code == SC_LSHIFT) r_shift_l <= !r_brk;
                  else                     r_shift_r <= !r_brk;
`ifdef PS2_TYPEMATIC_FILTER_EN
                  if (r_brk) r_last_vld <= 1'b0;
`endif
                  r_brk <= 1'b0;
               end else if (r_brk) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                  r_last_vld <= 1'b0;
`endif
                  r_brk <= 1'b0;
               end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                  r_last_code <= r_code;
                  r_last_vld  <= 1'b1;
`endif
               end
            end
            default: begin
               r_state  <= IDLE;
               r_kb_rdn <= 1'b1;
            end
         endcase
      end
   end

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign w_empty  = (r_wr == r_rd);
   assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop    = i_cpu_rd && !w_empty;
   assign w_wr_en  = w_push && (!w_full || w_pop);
   assign w_drop   = w_push && w_full && !w_pop;
   assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_wr_en};
   assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};
   assign w_empty_nxt = (w_wr_nxt == w_rd_nxt);

   // The next head may be the slot being written this very cycle.
   assign w_head_nxt = (w_wr_en && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0])) ? w_lut
                                                                     : r_mem[w_rd_nxt[AW-1:0]];

   always_ff @(posedge clk200m) begin
      if (w_wr_en) begin
         r_mem[r_wr[AW-1:0]] <= w_lut;
      end
   end

   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) begin
         r_wr          <= '0;
         r_rd          <= '0;
         r_ascii_data  <= ASCII_NONE;
         r_ascii_valid <= 1'b0;
         r_fifo_ovf    <= 1'b0;
      end else begin
         r_wr          <= w_wr_nxt;
         r_rd          <= w_rd_nxt;
         r_ascii_valid <= !w_empty_nxt;
         r_ascii_data  <= w_empty_nxt ? ASCII_NONE : w_head_nxt;
         if (w_pop) begin
            r_fifo_ovf <= 1'b0;
         end else if (w_drop) begin
            r_fifo_ovf <= 1'b1;
         end
      end
   end

   assign o_kb_rdn      = r_kb_rdn;
   assign o_ascii_data  = r_ascii_data;
   assign o_ascii_valid = r_ascii_valid;
   assign o_fifo_ovf    = r_fifo_ovf;
   assign o_shift_held  = r_shift_l | r_shift_r;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
// ============================================================================
// tb_ps2_scan_decoder : directed + random scancode stimulus vs. ASCII model.
// Honours PS2_TYPEMATIC_FILTER_EN the same way as the design.       Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scan_decoder;

`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif
   localparam int DEPTH = 8;

   logic       clk200m = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_rdn;
   logic       cpu_rd = 1'b0;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       fifo_ovf;
   logic       shift_held;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] mq[$];
   bit  m_ovf, m_brk, m_ext, m_sl, m_sr;
   int  m_last = -1;

   logic [7:0] LET [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                            8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] DIG [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [7:0] POOL [18] = '{8'h1C,8'h32,8'h21,8'h16,8'h1E,8'h45,8'h29,8'h5A,8'h66,8'h0D,8'h76,
                             8'hF0,8'hF0,8'hE0,8'h12,8'h59,8'h75,8'h7E};
   string SYM = ")!@#$%^&*(";

   ps2_scan_decoder dut (
      .clk200m       (clk200m),
      .rst           (rst),
      .i_kb_data     (kb_data),
      .i_kb_ready    (kb_ready),
      .o_kb_rdn      (kb_rdn),
      .i_cpu_rd      (cpu_rd),
      .o_ascii_data  (ascii_data),
      .o_ascii_valid (ascii_valid),
      .o_fifo_ovf    (fifo_ovf),
      .o_shift_held  (shift_held)
   );

   always #5 clk200m = ~clk200m;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lut_model(input logic [7:0] c, input bit sh);
      for (int i = 0; i < 26; i++)
         if (LET[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (DIG[i] == c) return sh ? SYM[i] : 8'h30 + 8'(i);
      case (c)
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         8'h0D: return 8'h09;
         8'h76: return 8'h1B;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0; m_last = -1;
   endtask

   task automatic model_pop();
      if (mq.size() > 0) begin
         void'(mq.pop_front());
         m_ovf = 0;
      end
   endtask

   task automatic model_scan(input logic [7:0] c);
      logic [7:0] ch;
      bit skip;
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else if (m_ext) begin
         if (m_brk) m_last = -1;
         m_brk = 0; m_ext = 0;
      end else if (c == 8'h12 || c == 8'h59) begin
         if (c == 8'h12) m_sl = !m_brk; else m_sr = !m_brk;
         if (m_brk) m_last = -1;
         m_brk = 0;
      end else if (m_brk) begin
         m_brk = 0; m_last = -1;
      end else begin
         ch   = lut_model(c, m_sl || m_sr);
         skip = FILTER && (m_last == int'(c));
         m_last = int'(c);
         if (!skip && ch != 8'h00) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back(ch);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, {7'd0, ascii_valid}, {7'd0, mq.size() > 0});
      chk({tag, ".data"},  ascii_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk({tag, ".ovf"},   {7'd0, fifo_ovf}, {7'd0, m_ovf});
      chk({tag, ".shift"}, {7'd0, shift_held}, {7'd0, m_sl | m_sr});
   endtask

   // Present one scancode like ps2_kbd would; optionally strobe cpu_rd in the decode cycle.
   task automatic send(input logic [7:0] code, input bit rd);
      int n = 0;
      int w = 0;
      @(negedge clk200m);
      kb_data  = code;
      kb_ready = 1'b1;
      while (kb_rdn !== 1'b0 && n < 20) begin
         @(negedge clk200m);
         n++;
      end
      chk("pop_latency", 8'(n), 8'd1);
      while (kb_rdn === 1'b0 && w < 20) begin
         @(negedge clk200m);
         w++;
      end
      chk("pop_width", 8'(w), 8'd2);
      kb_ready = 1'b0;
      @(negedge clk200m);
      @(negedge clk200m);
      check_outputs("pre_decode");
      if (rd) cpu_rd = 1'b1;
      @(negedge clk200m);
      cpu_rd = 1'b0;
      if (rd) model_pop();
      model_scan(code);
      check_outputs("post_decode");
      chk("rdn_idle", {7'd0, kb_rdn}, 8'd1);
   endtask

   task automatic cpu_read();
      @(negedge clk200m);
      cpu_rd = 1'b1;
      @(negedge clk200m);
      cpu_rd = 1'b0;
      model_pop();
      check_outputs("cpu_read");
   endtask

   task automatic drain();
      int k = mq.size();
      for (int i = 0; i < k; i++) cpu_read();
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1;
      chk("reset.rdn", {7'd0, kb_rdn}, 8'd1);
      check_outputs("reset");
      repeat (3) @(negedge clk200m);
      rst = 1'b0;

      // single key, latency and pulse shape
      send(8'h1C, 1'b0);
      chk("first_char", ascii_data, 8'h61);
      drain();

      // shifted 'A' and shift tracking
      send(8'h12, 1'b0);
      chk("shift_down", {7'd0, shift_held}, 8'd1);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h12, 1'b0);
      chk("shift_up", {7'd0, shift_held}, 8'd0);
      chk("shift_char", ascii_data, 8'h41);
      cpu_read();
      chk("empty_data", ascii_data, 8'h00);

      // extended make/break are discarded
      send(8'hE0, 1'b0);
      send(8'h75, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h75, 1'b0);
      send(8'h1C, 1'b0);
      chk("after_ext", ascii_data, 8'h61);
      drain();

      // overflow and sticky flag
      for (int i = 0; i < 9; i++) send(8'h1C, 1'b0);
      cpu_read();
      drain();
      cpu_read();

      // full FIFO with pop coinciding with push
      for (int i = 0; i < DEPTH; i++) send(LET[i], 1'b0);
      send(LET[DEPTH], 1'b1);
      chk("full_pop_ovf", {7'd0, fifo_ovf}, 8'd0);
      drain();

      // randomized scancodes and reads
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) cpu_read();
         else send(POOL[$urandom_range(0, 17)], $urandom_range(0, 3) == 0);
      end
      if (m_brk) send(8'h1C, 1'b0);
      if (m_ext) send(8'h1C, 1'b0);

      // reset in the middle of a pop
      send(8'h32, 1'b0);
      @(negedge clk200m);
      kb_data  = 8'h1C;
      kb_ready = 1'b1;
      @(negedge clk200m);
      chk("midpop.rdn_low", {7'd0, kb_rdn}, 8'd0);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("midpop.rdn", {7'd0, kb_rdn}, 8'd1);
      check_outputs("midpop");
      kb_ready = 1'b0;
      @(negedge clk200m);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send(8'h1C, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
